mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory bus between the IF-stage instruction fetch port and the MEM-stage data port of the 5-stage pipeline.
- Sequences one outstanding transaction at a time with a req/gnt/rvalid handshake.
- Data port has priority; a starvation counter guarantees fetch progress.
- Sits between the pipeline front/back ends and the memory model/controller.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- MAX_IF_WAIT, 4, consecutive IF wait cycles after which IF wins the next arbitration (range 1..255).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- if_req_i  in  1  fetch request; held stable with address until if_gnt_o
- if_addr_i  in  ADDR_W  fetch address
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch data valid
- if_rdata_o  out  DATA_W  fetch data
- dm_req_i  in  1  data request; held stable with all attributes until dm_gnt_o
- dm_we_i  in  1  1 = store, 0 = load
- dm_be_i  in  DATA_W/8  byte enables
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  store data
- dm_gnt_o  out  1  data request accepted
- dm_rvalid_o  out  1  load data / store ack valid
- dm_rdata_o  out  DATA_W  load data
- mem_req_o  out  1  bus request
- mem_we_o  out  1  bus write
- mem_be_o  out  DATA_W/8  bus byte enables
- mem_addr_o  out  ADDR_W  bus address
- mem_wdata_o  out  DATA_W  bus write data
- mem_gnt_i  in  1  bus accepted request
- mem_rvalid_i  in  1  bus response (for reads and writes)
- mem_rdata_i  in  DATA_W  bus read data

Behaviour:
- Reset state: all gnt/rvalid/mem_* outputs 0, FSM in IDLE, owner = DM, wait counter = 0.
- if_rdata_o and dm_rdata_o are combinational copies of mem_rdata_i; they are meaningful only when the matching rvalid is high.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - If any request is pending, select the owner combinationally and drive mem_* from it in the same cycle.
  - Selection: DM wins if dm_req_i, unless if_req_i is high and wait_cnt >= MAX_IF_WAIT, in which case IF wins.
  - If mem_gnt_i is high: pulse the owner's gnt and go to WAIT. Otherwise go to REQ with the owner latched.
- REQ:
  - Owner is locked; no switching even if a higher-priority request arrives.
  - mem_* continues to be driven from the latched owner.
  - On mem_gnt_i: pulse owner gnt, go to WAIT.
- WAIT:
  - mem_req_o = 0.
  - On mem_rvalid_i: pulse the owner's rvalid for one cycle and go to IDLE.
  - The next issue occurs no earlier than the following cycle, so minimum occupancy per transaction is 2 cycles with zero-latency gnt and 1-cycle rvalid.
- Gnt pass-through: gnt to a requester is mem_gnt_i AND owner match, combinational in the same cycle as mem_req_o.
- Wait counter (saturating at 255):
  - Increments each cycle if_req_i is high and if_gnt_o is low.
  - Clears on if_gnt_o or when if_req_i is low.
- Boundary cases:
  - mem_rvalid_i in IDLE or REQ is spurious: ignored, no rvalid pulse.
  - Simultaneous if_req_i and dm_req_i with wait_cnt < MAX_IF_WAIT: DM granted first, IF next.
  - rst_n low mid-transaction: immediate return to reset state; any in-flight response is dropped (memory shares the same reset).
  - A requester deasserting its req before gnt is illegal. Behaviour is undefined, but the FSM must not deadlock: REQ still waits for mem_gnt_i.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- When defined, adds three outputs, each 32 bits, wrapping, cleared on reset:
  - perf_if_stall_o: cycles with if_req_i high and if_gnt_o low.
  - perf_dm_stall_o: cycles with dm_req_i high and dm_gnt_o low.
  - perf_conflict_o: IDLE cycles with both requests high.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Add to riscv_pkg:
  - arb_state_e {ARB_IDLE, ARB_REQ, ARB_WAIT}
  - arb_owner_e {OWN_IF, OWN_DM}
  - localparam ARB_WAIT_CNT_W = 8
- One natural sub-module: arb_wait_counter, the saturating starvation counter with clear and threshold-compare output.

Test Plan:
- Reset: hold rst_n=0 with both reqs high → all gnt/rvalid/mem_req_o = 0. Release → DM granted first (dm_addr_i=0x100 appears on mem_addr_o).
- Single fetch, mem_gnt_i tied 1, rvalid 1 cycle later with rdata 0x00000013 → if_gnt_o in cycle 0, if_rvalid_o in cycle 1 with if_rdata_o=0x13, dm_rvalid_o stays 0.
- Store, dm_we_i=1, be=4'b0011, wdata=0xDEADBEEF, mem_gnt_i delayed 3 cycles → FSM in REQ; mem_* stable for 3 cycles; dm_gnt_o exactly on the 4th cycle; dm_rvalid_o on ack.
- Starvation: MAX_IF_WAIT=4, dm_req_i held high continuously, if_req_i high → IF granted on the arbitration after wait_cnt reaches 4, then DM resumes.
- Owner lock: IF in REQ (gnt stalled), dm_req_i rises → mem_addr_o stays the IF address and the IF transaction completes before DM is granted.
- Spurious mem_rvalid_i in IDLE → no rvalid pulse. rst_n asserted in WAIT → FSM goes to IDLE and the late response is ignored.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/DM memory port arbiter: FSM states, bus owner
// encoding and the starvation-counter width.
package mem_port_arbiter_pkg;

  localparam int ARB_WAIT_CNT_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_WAIT
  } arb_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } arb_owner_e;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating count of consecutive cycles the fetch port has waited, with a
// threshold flag telling the arbiter that fetch must win the next arbitration.
module arb_wait_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_IF_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_if_req,
  input  logic i_if_gnt,
  output logic o_starved
);

  localparam logic [ARB_WAIT_CNT_W-1:0] THRESH = ARB_WAIT_CNT_W'(MAX_IF_WAIT);

  logic [ARB_WAIT_CNT_W-1:0] r_cnt;

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_if_req || i_if_gnt) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_starved = (r_cnt >= THRESH);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory bus between the fetch (IF) and data (DM)
// ports, one transaction in flight. Optional counters: MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_IF_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                dm_req_i,
  input  logic                dm_we_i,
  input  logic [DATA_W/8-1:0] dm_be_i,
  input  logic [ADDR_W-1:0]   dm_addr_i,
  input  logic [DATA_W-1:0]   dm_wdata_i,
  output logic                dm_gnt_o,
  output logic                dm_rvalid_o,
  output logic [DATA_W-1:0]   dm_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]         perf_if_stall_o,
  output logic [31:0]         perf_dm_stall_o,
  output logic [31:0]         perf_conflict_o
`endif
);

  arb_state_e r_state;
  arb_owner_e r_owner;
  arb_owner_e w_sel_owner;
  arb_owner_e w_owner;
  logic       w_starved;
  logic       w_any_req;
  logic       w_issue;
  logic       w_resp;

  arb_wait_counter #(
    .MAX_IF_WAIT(MAX_IF_WAIT)
  ) u_wait_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_if_req (if_req_i),
    .i_if_gnt (if_gnt_o),
    .o_starved(w_starved)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_any_req   = if_req_i | dm_req_i;
    w_sel_owner = OWN_DM;
    if (if_req_i && (!dm_req_i || w_starved)) w_sel_owner = OWN_IF;
    w_owner = (r_state == ARB_IDLE) ? w_sel_owner : r_owner;
    // Gated by rst_n so the bus stays quiet while reset is held with requests pending.
    w_issue = rst_n && (((r_state == ARB_IDLE) && w_any_req) || (r_state == ARB_REQ));
    w_resp  = (r_state == ARB_WAIT) && mem_rvalid_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_owner <= OWN_DM;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_any_req) begin
            r_owner <= w_sel_owner;
            r_state <= mem_gnt_i ? ARB_WAIT : ARB_REQ;
          end
        end
        ARB_REQ:  if (mem_gnt_i)    r_state <= ARB_WAIT;
        ARB_WAIT: if (mem_rvalid_i) r_state <= ARB_IDLE;
        default:                    r_state <= ARB_IDLE;
      endcase
    end
  end

  // Fetches are always full-word reads; attributes are zero whenever the bus is idle.
  always_comb begin
    mem_req_o   = w_issue;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (w_issue) begin
      if (w_owner == OWN_IF) begin
        mem_be_o   = '1;
        mem_addr_o = if_addr_i;
      end else begin
        mem_we_o    = dm_we_i;
        mem_be_o    = dm_be_i;
        mem_addr_o  = dm_addr_i;
        mem_wdata_o = dm_wdata_i;
      end
    end
  end

  assign if_gnt_o    = w_issue && mem_gnt_i && (w_owner == OWN_IF);
  assign dm_gnt_o    = w_issue && mem_gnt_i && (w_owner == OWN_DM);
  assign if_rvalid_o = w_resp && (r_owner == OWN_IF);
  assign dm_rvalid_o = w_resp && (r_owner == OWN_DM);
  assign if_rdata_o  = mem_rdata_i;
  assign dm_rdata_o  = mem_rdata_i;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] r_perf_if_stall;
  logic [31:0] r_perf_dm_stall;
  logic [31:0] r_perf_conflict;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_if_stall <= '0;
      r_perf_dm_stall <= '0;
      r_perf_conflict <= '0;
    end else begin
      if (if_req_i && !if_gnt_o) r_perf_if_stall <= r_perf_if_stall + 32'd1;
      if (dm_req_i && !dm_gnt_o) r_perf_dm_stall <= r_perf_dm_stall + 32'd1;
      if ((r_state == ARB_IDLE) && if_req_i && dm_req_i)
        r_perf_conflict <= r_perf_conflict + 32'd1;
    end
  end

  assign perf_if_stall_o = r_perf_if_stall;
  assign perf_dm_stall_o = r_perf_dm_stall;
  assign perf_conflict_o = r_perf_conflict;
`endif

endmodule
